// File: rtl/frame_writer.sv
// Per-frame scan engine: sweeps the screen, realigns horizon ROM data and writes the frame buffer.
// Define FW_BG_FILL_EN to write BG_COLOR for unqualified pixels instead of skipping them.
module frame_writer #(
   parameter int unsigned      SCREEN_W    = 640,
   parameter int unsigned      SCREEN_H    = 480,
   parameter int unsigned      ROM_LAT     = 2,
   parameter int unsigned      PIX_W       = 4,
   parameter logic [PIX_W-1:0] TRANSPARENT = '0,
   parameter logic [PIX_W-1:0] BG_COLOR    = PIX_W'(1)
) (
   input  logic             Clk50,
   input  logic             Reset,
   input  logic             frame_start,
   output logic [9:0]       WriteX,
   output logic [9:0]       WriteY,
   input  logic             horizon_on_wr,
   input  logic [17:0]      horizon_address,
   output logic [17:0]      rom_addr,
   output logic             rom_en,
   input  logic [PIX_W-1:0] rom_data,
   output logic [18:0]      fb_addr,
   output logic [PIX_W-1:0] fb_data,
   output logic             fb_we,
   input  logic             fb_ready,
   output logic             busy,
   output logic             frame_done
);

   typedef enum logic [1:0] {StIdle, StScan, StDrain} state_t;

   state_t                    state;
   logic [18:0]               pix_cnt;
   logic [ROM_LAT-1:0]        st_valid;
   logic [ROM_LAT-1:0]        st_on;
   logic [ROM_LAT-1:0][18:0]  st_addr;
   logic                      advance;
   logic                      last_x;
   logic                      last_y;
   logic                      qualified;
   logic                      wr_en;
   logic [PIX_W-1:0]          pix_data;

   // A pending write that is not accepted freezes the whole scan and ROM pipeline.
   assign advance    = !(fb_we && !fb_ready);
   assign rom_addr   = horizon_address;
   assign rom_en     = (state != StIdle) && advance;
   assign busy       = (state != StIdle);
   assign frame_done = (state == StDrain) && (st_valid == '0) && advance;
   assign last_x     = (WriteX == 10'(SCREEN_W - 1));
   assign last_y     = (WriteY == 10'(SCREEN_H - 1));
   assign qualified  = st_on[ROM_LAT-1] && (rom_data != TRANSPARENT);
   assign pix_data   = qualified ? rom_data : BG_COLOR;

`ifdef FW_BG_FILL_EN
   assign wr_en = st_valid[ROM_LAT-1];
`else
   assign wr_en = st_valid[ROM_LAT-1] && qualified;
`endif

   always_ff @(posedge Clk50 or posedge Reset) begin
      if (Reset) begin
         state    <= StIdle;
         WriteX   <= '0;
         WriteY   <= '0;
         pix_cnt  <= '0;
         st_valid <= '0;
         st_on    <= '0;
         st_addr  <= '0;
         fb_we    <= 1'b0;
         fb_addr  <= '0;
         fb_data  <= '0;
      end else begin
         // Stage 0 is loaded with the coordinate issued this cycle; the last stage
         // lines up with rom_data because the ROM advances on the same enable.
         if (state != StIdle && advance) begin
            for (int unsigned i = 1; i < ROM_LAT; i++) begin
               st_valid[i] <= st_valid[i-1];
               st_on[i]    <= st_on[i-1];
               st_addr[i]  <= st_addr[i-1];
            end
            st_valid[0] <= (state == StScan);
            st_on[0]    <= horizon_on_wr;
            st_addr[0]  <= pix_cnt;
            fb_we       <= wr_en;
            if (wr_en) begin
               fb_addr <= st_addr[ROM_LAT-1];
               fb_data <= pix_data;
            end
         end

         case (state)
            StIdle: begin
               if (frame_start) begin
                  state   <= StScan;
                  WriteX  <= '0;
                  WriteY  <= '0;
                  pix_cnt <= '0;
               end
            end
            StScan: begin
               if (advance) begin
                  if (last_x) begin
                     WriteX <= '0;
                     if (last_y) begin
                        WriteY  <= '0;
                        pix_cnt <= '0;
                        state   <= StDrain;
                     end else begin
                        WriteY  <= WriteY + 10'd1;
                        pix_cnt <= pix_cnt + 19'd1;
                     end
                  end else begin
                     WriteX  <= WriteX + 10'd1;
                     pix_cnt <= pix_cnt + 19'd1;
                  end
               end
            end
            StDrain: begin
               if (frame_done) state <= StIdle;
            end
            default: state <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_frame_writer.sv
// Bench for frame_writer on a reduced 16x12 screen with a 2-cycle enabled ROM model.
module tb_frame_writer;

   localparam int W = 16;
   localparam int H = 12;
   localparam int L = 2;
   localparam int N = W * H;
   localparam int STALL_ADDR = 8 * W + 10;

   logic        clk = 1'b0;
   logic        Reset = 1'b1;
   logic        frame_start = 1'b0;
   logic [9:0]  WriteX, WriteY;
   logic        horizon_on_wr;
   logic [17:0] horizon_address;
   logic [17:0] rom_addr;
   logic        rom_en;
   logic [3:0]  rom_data;
   logic [18:0] fb_addr;
   logic [3:0]  fb_data;
   logic        fb_we;
   logic        fb_ready;
   logic        busy, frame_done;

   int checks = 0;
   int errors = 0;

   int mode = 0;
   bit rand_en = 1'b0;
   bit stall_en = 1'b0;
   bit rnd_ready = 1'b1;
   int stall_cnt = 0;
   logic stall_active;
   logic [9:0] frozen_x;

   int exp_mem [0:N-1];
   int exp_n = 0;
   int base = 0;
   int rd_idx = 0;
   int done_cnt = 0;
   int first_addr = -1;
   int first_data = -1;
   logic [3:0] r1 = '0, r2 = '0;

   typedef struct {
      int mode; bit rnd; bit stall; bit mid; bit lat;
      int nwr; int faddr; int fdata;
   } vec_t;
   vec_t vecs [6];

   frame_writer #(.SCREEN_W(W), .SCREEN_H(H), .ROM_LAT(L)) dut (
      .Clk50(clk), .Reset(Reset), .frame_start(frame_start),
      .WriteX(WriteX), .WriteY(WriteY),
      .horizon_on_wr(horizon_on_wr), .horizon_address(horizon_address),
      .rom_addr(rom_addr), .rom_en(rom_en), .rom_data(rom_data),
      .fb_addr(fb_addr), .fb_data(fb_data), .fb_we(fb_we), .fb_ready(fb_ready),
      .busy(busy), .frame_done(frame_done)
   );

   always #5 clk = ~clk;

   function automatic logic hon(input int m, input int y);
      if (m == 0) return 1'b0;
      if (m == 2) return 1'b1;
      return (y >= 8) && (y <= 9);
   endfunction

   function automatic logic [3:0] rom_val(input int m, input int a);
      if (m == 2) return (a % 2 == 1) ? 4'h5 : 4'h0;
      return 4'h5;
   endfunction

   // Stand-in for draw_horizon and the sprite ROM.
   assign horizon_on_wr   = hon(mode, int'(WriteY));
   assign horizon_address = 18'(int'(WriteY) * W + int'(WriteX));
   always @(posedge clk) if (rom_en) begin
      r1 <= rom_val(mode, int'(rom_addr));
      r2 <= r1;
   end
   assign rom_data = r2;

   assign stall_active = stall_en && fb_we && (int'(fb_addr) == STALL_ADDR) && (stall_cnt < 7);
   assign fb_ready = rnd_ready && !stall_active;

   always @(posedge clk) begin
      if (frame_start) stall_cnt <= 0;
      else if (stall_active) stall_cnt <= stall_cnt + 1;
   end

   always @(posedge clk) begin
      #1;
      if (rand_en) rnd_ready = ($urandom_range(0, 3) != 0);
      else rnd_ready = 1'b1;
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: every accepted write must be the next expected {addr, data}.
   always @(negedge clk) if (!Reset) begin
      if (frame_done) done_cnt++;
      if (fb_we && fb_ready) begin
         if (rd_idx - base == 0) begin
            first_addr = int'(fb_addr);
            first_data = int'(fb_data);
         end
         if (rd_idx - base >= exp_n) check("unexpected_write", {9'd0, fb_addr, fb_data}, 32'hFFFF_FFFF);
         else check("write", {9'd0, fb_addr, fb_data}, exp_mem[rd_idx - base]);
         rd_idx++;
      end
   end

   always @(negedge clk) if (stall_active) begin
      if (stall_cnt == 0) frozen_x = WriteX;
      else check("stall_writex", 32'(WriteX), 32'(frozen_x));
      check("stall_we", 32'(fb_we), 1);
      check("stall_addr", 32'(fb_addr), STALL_ADDR);
      check("stall_data", 32'(fb_data), 5);
      check("stall_rom_en", 32'(rom_en), 0);
   end

   task automatic prep(input vec_t v);
      int a;
      logic [3:0] d;
      logic q;
      mode = v.mode;
      rand_en = v.rnd;
      stall_en = v.stall;
      exp_n = 0;
      for (int y = 0; y < H; y++) begin
         for (int x = 0; x < W; x++) begin
            a = y * W + x;
            d = rom_val(v.mode, a);
            q = hon(v.mode, y) && (d != 4'h0);
`ifdef FW_BG_FILL_EN
            exp_mem[exp_n] = a * 16 + (q ? int'(d) : 1);
            exp_n++;
`else
            if (q) begin
               exp_mem[exp_n] = a * 16 + int'(d);
               exp_n++;
            end
`endif
         end
      end
      base = rd_idx;
      first_addr = -1;
      first_data = -1;
   endtask

   task automatic run_frame(input vec_t v);
      int cyc;
      int dbase;
      bit got;
      prep(v);
      dbase = done_cnt;
      @(posedge clk); #1;
      frame_start = 1'b1;
      cyc = 0;
      got = 1'b0;
      while (!got && cyc < 2000) begin
         @(negedge clk);
         if (cyc >= 1) frame_start = 1'b0;
         if (v.mid && cyc == 60) frame_start = 1'b1;
         if (cyc == 1) begin
            check("start_busy", 32'(busy), 1);
            check("start_x", 32'(WriteX), 0);
            check("start_y", 32'(WriteY), 0);
         end
         if (frame_done) got = 1'b1;
         else cyc++;
      end
      frame_start = 1'b0;
      check("frame_done_seen", 32'(got), 1);
      if (v.lat) check("frame_latency", cyc, N + L + 1);
      repeat (3) @(negedge clk);
      check("write_count", rd_idx - base, v.nwr);
      if (v.nwr > 0) begin
         check("first_addr", first_addr, v.faddr);
         check("first_data", first_data, v.fdata);
      end
      check("done_pulses", done_cnt - dbase, 1);
      check("idle_busy", 32'(busy), 0);
      rand_en = 1'b0;
      stall_en = 1'b0;
   endtask

   initial begin
      vecs[0] = '{mode: 0, rnd: 0, stall: 0, mid: 0, lat: 1, nwr: 0,  faddr: 0,   fdata: 0};
      vecs[1] = '{mode: 1, rnd: 0, stall: 0, mid: 0, lat: 1, nwr: 32, faddr: 128, fdata: 5};
`ifdef FW_BG_FILL_EN
      vecs[2] = '{mode: 2, rnd: 0, stall: 0, mid: 0, lat: 1, nwr: N,  faddr: 0,   fdata: 1};
`else
      vecs[2] = '{mode: 2, rnd: 0, stall: 0, mid: 0, lat: 1, nwr: 96, faddr: 1,   fdata: 5};
`endif
      vecs[3] = '{mode: 1, rnd: 1, stall: 0, mid: 0, lat: 0, nwr: 32, faddr: 128, fdata: 5};
      vecs[4] = '{mode: 1, rnd: 0, stall: 1, mid: 0, lat: 0, nwr: 32, faddr: 128, fdata: 5};
      vecs[5] = '{mode: 0, rnd: 0, stall: 0, mid: 1, lat: 1, nwr: 0,  faddr: 0,   fdata: 0};
`ifdef FW_BG_FILL_EN
      vecs[0].nwr = N; vecs[0].faddr = 0; vecs[0].fdata = 1;
      vecs[1].nwr = N; vecs[1].faddr = 0; vecs[1].fdata = 1;
      vecs[3].nwr = N; vecs[3].faddr = 0; vecs[3].fdata = 1;
      vecs[4].nwr = N; vecs[4].faddr = 0; vecs[4].fdata = 1;
      vecs[5].nwr = N; vecs[5].faddr = 0; vecs[5].fdata = 1;
`endif

      repeat (3) @(posedge clk);
      #1;
      check("rst_x", 32'(WriteX), 0);
      check("rst_y", 32'(WriteY), 0);
      check("rst_we", 32'(fb_we), 0);
      check("rst_addr", 32'(fb_addr), 0);
      check("rst_data", 32'(fb_data), 0);
      check("rst_busy", 32'(busy), 0);
      check("rst_done", 32'(frame_done), 0);
      check("rst_rom_en", 32'(rom_en), 0);
      @(negedge clk);
      Reset = 1'b0;

      for (int i = 0; i < 6; i++) run_frame(vecs[i]);

      // Abandon a frame mid-scan with an asynchronous reset.
      prep(vecs[1]);
      @(posedge clk); #1;
      frame_start = 1'b1;
      @(posedge clk); #1;
      frame_start = 1'b0;
      for (int i = 0; i < 500 && !(WriteY == 10'd9 && WriteX == 10'd5); i++) @(negedge clk);
      check("reach_y9", 32'(WriteY), 9);
      #1 Reset = 1'b1;
      #1;
      check("arst_x", 32'(WriteX), 0);
      check("arst_y", 32'(WriteY), 0);
      check("arst_we", 32'(fb_we), 0);
      check("arst_addr", 32'(fb_addr), 0);
      check("arst_data", 32'(fb_data), 0);
      check("arst_busy", 32'(busy), 0);
      check("arst_rom_en", 32'(rom_en), 0);
      repeat (3) begin
         @(negedge clk);
         check("arst_hold_we", 32'(fb_we), 0);
         check("arst_hold_busy", 32'(busy), 0);
      end
      Reset = 1'b0;
      repeat (2) @(negedge clk);
      check("arst_idle_we", 32'(fb_we), 0);
      run_frame(vecs[1]);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
